// File: rtl/gamma_pkg.sv
// ---------------------------------------------------------------------------
// gamma_pkg
// Shared definitions for the multi-channel gamma LUT stage.
//   - gamma_state_t : bank-swap controller states
//   - DEFAULT_DW    : default bits per channel (LUT depth is 2**DW)
//   - DEFAULT_CH    : default channel count
//   - ch_sel_width(): width of the channel-select field, never below 1
// ---------------------------------------------------------------------------
package gamma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SWAP  = 2'd2
    } gamma_state_t;

    localparam int DEFAULT_DW = 8;
    localparam int DEFAULT_CH = 3;

    // A single-channel build still needs a one-bit select field.
    function automatic int ch_sel_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/gamma_lut_multi_if.sv
// ---------------------------------------------------------------------------
// gamma_lut_multi_if
// Host configuration bus of the gamma LUT stage.
//   cfg_we      : write strobe into the shadow bank
//   cfg_ch      : target channel (values >= CH are ignored)
//   cfg_addr    : table index
//   cfg_wdata   : table entry
//   cfg_commit  : one-cycle request to swap banks at the next frame start
//   cfg_bypass  : requested identity mode, applied at the next frame start
//   cfg_busy    : a swap is pending
//   active_bank : bank currently used by the pixel path
// Modports: master = host side, slave = gamma_lut_multi side.
// ---------------------------------------------------------------------------
interface gamma_lut_multi_if
    import gamma_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int CH = DEFAULT_CH
);

    localparam int CHW = ch_sel_width(CH);

    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [DW-1:0]  cfg_addr;
    logic [DW-1:0]  cfg_wdata;
    logic           cfg_commit;
    logic           cfg_bypass;
    logic           cfg_busy;
    logic           active_bank;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_addr,
        output cfg_wdata,
        output cfg_commit,
        output cfg_bypass,
        input  cfg_busy,
        input  active_bank
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_addr,
        input  cfg_wdata,
        input  cfg_commit,
        input  cfg_bypass,
        output cfg_busy,
        output active_bank
    );

endinterface

// File: rtl/gamma_lut_bank.sv
// ---------------------------------------------------------------------------
// gamma_lut_bank
// One channel of the gamma stage: two 2**DW x DW tables held in a single
// synchronous RAM, addressed as {bank, index}.
//   clk     : pixel clock
//   we      : write strobe
//   wr_bank : bank receiving the write
//   wr_addr : write index
//   wr_data : write data
//   rd_bank : bank feeding the pixel path
//   rd_addr : read index (the raw channel value)
//   rd_data : registered table output, one cycle after rd_addr
// Contents are deliberately not reset so tables survive a pipeline reset.
// ---------------------------------------------------------------------------
module gamma_lut_bank #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wr_bank,
    input  logic [DW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_bank,
    input  logic [DW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int DEPTH = 2 ** (DW + 1);

    logic [DW-1:0] mem [DEPTH];

    // Single write port and single read port; the controller guarantees the
    // two ports always target different banks, so no collision handling.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
        rd_data <= mem[{rd_bank, rd_addr}];
    end

endmodule

// File: rtl/gamma_lut_multi.sv
// ---------------------------------------------------------------------------
// gamma_lut_multi
// Double-buffered, runtime-reprogrammable gamma correction for CH channels of
// DW bits. The host fills the shadow bank, commits, and the banks swap at the
// next rising edge of i_vsync so a frame never mixes two curves.
//   clk, rst          : pixel clock, synchronous active-high reset
//   i_data            : input pixel, channel 0 in the LSBs
//   i_vsync/hsync/valid : input sidebands
//   o_data            : corrected pixel, two cycles after i_data
//   o_vsync/hsync/valid : sidebands delayed by the same two cycles
//   cfg_bus           : host configuration bus (slave side)
// ---------------------------------------------------------------------------
module gamma_lut_multi
    import gamma_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int CH = DEFAULT_CH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CH*DW-1:0] i_data,
    input  logic             i_vsync,
    input  logic             i_hsync,
    input  logic             i_valid,
    output logic [CH*DW-1:0] o_data,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_valid,
    gamma_lut_multi_if.slave cfg_bus
);

    localparam int CHW = ch_sel_width(CH);

    gamma_state_t     state;
    gamma_state_t     state_next;
    logic             vsync_d;
    logic             frame_start;
    logic             active_bank;
    logic             bypass_act;
    logic             wr_accept;
    logic             rd_bank;
    logic [CH*DW-1:0] lut_data;
    logic [CH*DW-1:0] s1_raw;
    logic             s1_vsync;
    logic             s1_hsync;
    logic             s1_valid;
    logic             s1_bypass;

    // Frame start is the first cycle of a high i_vsync.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d <= 1'b0;
        end else begin
            vsync_d <= i_vsync;
        end
    end

    assign frame_start = i_vsync & ~vsync_d;

    // Controller state and the visible bank pointer. The pointer flips on the
    // edge that ends SWAP, which is also when cfg_busy drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            active_bank <= 1'b0;
        end else begin
            state <= state_next;
            if (state == SWAP) begin
                active_bank <= ~active_bank;
            end
        end
    end

    // Writes are only accepted while idle: once a commit is armed the shadow
    // bank is frozen, and during SWAP it is about to become the live bank.
    always_comb begin
        state_next = state;
        wr_accept  = 1'b0;
        case (state)
            IDLE: begin
                wr_accept = cfg_bus.cfg_we;
                if (cfg_bus.cfg_commit) begin
                    state_next = ARMED;
                end
            end
            ARMED: begin
                if (frame_start) begin
                    state_next = SWAP;
                end
            end
            SWAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bypass is resampled at every frame start, independent of the swap logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass_act <= 1'b1;
        end else if (frame_start) begin
            bypass_act <= cfg_bus.cfg_bypass;
        end
    end

    // The pixel following a frame start is read during SWAP, one edge before
    // active_bank flips, so it already has to look at the incoming bank.
    assign rd_bank = active_bank ^ (state == SWAP);

    assign cfg_bus.cfg_busy    = (state != IDLE);
    assign cfg_bus.active_bank = active_bank;

    // One LUT per channel. A cfg_ch value with no matching channel simply
    // enables nothing, which drops out-of-range writes.
    for (genvar g = 0; g < CH; g++) begin : g_chan
        logic ch_we;

        assign ch_we = wr_accept && (cfg_bus.cfg_ch == CHW'(g));

        gamma_lut_bank #(
            .DW (DW)
        ) u_bank (
            .clk     (clk),
            .we      (ch_we),
            .wr_bank (~active_bank),
            .wr_addr (cfg_bus.cfg_addr),
            .wr_data (cfg_bus.cfg_wdata),
            .rd_bank (rd_bank),
            .rd_addr (i_data[g*DW +: DW]),
            .rd_data (lut_data[g*DW +: DW])
        );
    end

    // Stage 1: runs in parallel with the RAM read. The bypass flag travels
    // with the pixel so a frame-start change lands on the right pixel.
    // s1_bypass clears to 1 so nothing unloaded is selected after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_raw    <= '0;
            s1_vsync  <= 1'b0;
            s1_hsync  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b1;
        end else begin
            s1_raw    <= i_data;
            s1_vsync  <= i_vsync;
            s1_hsync  <= i_hsync;
            s1_valid  <= i_valid;
            s1_bypass <= bypass_act;
        end
    end

    // Stage 2: choose the table output or the raw pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_data  <= '0;
            o_vsync <= 1'b0;
            o_hsync <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            o_data  <= s1_bypass ? s1_raw : lut_data;
            o_vsync <= s1_vsync;
            o_hsync <= s1_hsync;
            o_valid <= s1_valid;
        end
    end

endmodule

// File: doc/gamma_lut_multi.md
# gamma_lut_multi

Runtime-reprogrammable, multi-channel gamma correction stage for the video pixel pipeline. Each of CH channels of DW bits is mapped through its own 2^DW-entry lookup table. Tables are double-buffered: the host writes the shadow bank while video runs, and banks swap only at a frame boundary (rising i_vsync), so no frame ever mixes curves. Sync sidebands are delayed to match the data latency, so the image does not shift.

## Interface
Parameters:
- DW, 8, bits per channel; LUT depth is 2^DW.
- CH, 3, channel count; channel 0 occupies i_data[DW-1:0], channel CH-1 is the MSBs.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- i_data  in  CH*DW  input pixel.
- i_vsync / i_hsync / i_valid  in  1 each  input sync and valid.
- o_data  out  CH*DW  corrected pixel.
- o_vsync / o_hsync / o_valid  out  1 each  sidebands delayed by 2 cycles.
- cfg_we  in  1  write strobe to the shadow bank.
- cfg_ch  in  max(1,$clog2(CH))  target channel; values ≥CH are ignored.
- cfg_addr  in  DW  table index.
- cfg_wdata  in  DW  table entry.
- cfg_commit  in  1  one-cycle pulse requesting a bank swap at the next frame start.
- cfg_bypass  in  1  requested bypass (identity) mode; takes effect at the next frame start.
- cfg_busy  out  1  high while a swap is pending.
- active_bank  out  1  bank currently used by the pixel path.

## Operation
- Per channel: two banks of 2^DW×DW synchronous RAM. The pixel path reads active_bank; cfg writes go to the other (shadow) bank.
- Frame start = cycle T where i_vsync=1 and the previous-cycle i_vsync=0. Detection uses a registered copy of i_vsync.
- FSM:
  - IDLE: writes accepted; cfg_busy=0. cfg_commit moves to ARMED.
  - ARMED: cfg_busy=1; cfg_we and cfg_commit are ignored and the shadow bank is frozen. A frame start moves to SWAP.
  - SWAP: one cycle; toggle active_bank, then return to IDLE.
- bypass_act is sampled from cfg_bypass at every frame start, in any state. When bypass_act=1, o_data equals the delayed i_data.
- Simultaneous events:
  - cfg_commit in IDLE in the same cycle as a frame start: enter ARMED; the swap happens at the following frame start.
  - cfg_we in the same cycle as cfg_commit in IDLE: the write is performed.
- Data is looked up regardless of i_valid. o_data is don't-care only when o_valid=0.
- Reset values:
  - o_data=0, o_vsync=o_hsync=o_valid=0.
  - active_bank=0, cfg_busy=0, FSM=IDLE, bypass_act=1.
  - RAM contents are not reset. The block outputs identity until the host loads tables, commits, and clears cfg_bypass.
- Reset mid-operation: a pending swap is discarded, pipeline registers clear, RAM contents are kept.

## Timing
- Latency is exactly 2 cycles for data and all sidebands.
  - Stage 1: RAM read; sidebands, bypass_act and raw data registered.
  - Stage 2: output mux (LUT or raw) registered.
- A pixel entering at cycle T+1 or later, relative to the frame-start cycle T, uses the post-swap bank and post-sample bypass_act. A pixel entering at cycle T uses the old settings.
- A cfg write at cycle t is readable by the pixel path only after a swap. There is no read-during-write hazard, because the banks are disjoint.
- active_bank changes on the clock edge ending SWAP. cfg_busy falls on that same edge.

## Structure
- Package gamma_pkg:
  - FSM state enum {IDLE, ARMED, SWAP}.
  - Default DW/CH constants.
  - Helper function for the cfg_ch width.
- Sub-module gamma_lut_bank: one channel, dual-bank sync RAM with one write port (bank select, addr, data) and one read port. Instantiated CH times via generate.
- Top level holds the FSM, vsync edge detect, bypass register and the sideband/raw-data delay lines.

## Test plan
- Reset, then drive i_data=0x123456 with i_valid=1 and no programming. Expect o_data=0x123456 two cycles later, o_valid aligned, active_bank=0.
- Load an inverted table (entry=255-addr) on all 3 channels, commit, set cfg_bypass=0, give one vsync rise. Expect i_data=0x102030 → o_data=0xEFDFCF. cfg_busy must be high from the commit until the SWAP edge.
- In ARMED, write addr 0x10=0x00 on channel 1. Expect the write to be ignored: after the swap, channel 1 input 0x10 → 0xEF.
- Pulse cfg_commit in the same cycle as a vsync rise. Expect no swap on that edge and a swap at the next rise.
- Toggle cfg_bypass mid-frame. Expect no change in o_data until the next frame start, then the change applies from pixel T+1.
- Assert rst while ARMED. Expect cfg_busy=0, active_bank unchanged-reset to 0, outputs 0, and no swap at the next vsync.
